// File: rtl/in_service_control.sv
// in_service_control
//   Sits after the 8259A priority resolver. Raises INT toward the CPU, runs the
//   two-pulse INTA acknowledge sequence (8086 mode) and owns the in-service
//   register together with EOI, auto-EOI and priority rotation.
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   interrupt[7:0]           one-hot winning request from the resolver (0 = none)
//   inta_n                   INTA strobe, active-low, synchronous to clk
//   vector_base[4:0]         ICW2 T7..T3
//   auto_eoi                 clear the ISR bit at the end of the 2nd INTA
//   eoi_nonspecific          pulse: clear the highest-priority ISR bit
//   eoi_specific, eoi_level  pulse: clear ISR bit eoi_level
//   eoi_rotate               with an EOI: the cleared level becomes lowest priority
//   int_out                  INT pin
//   clear_irr[7:0]           1-cycle pulse clearing the acknowledged IRR bit
//   freeze                   IRR must hold (1st INTA fall to 2nd INTA rise)
//   in_service_register      ISR
//   highest_level_in_service one-hot highest-priority ISR bit under rotation
//   data_out, data_out_en    vector byte and its bus enable
module in_service_control #(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       eoi_nonspecific,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  output logic       int_out,
  output logic [7:0] clear_irr,
  output logic       freeze,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  state_t     state;
  logic       inta_d;
  logic       fall;
  logic       rise;
  logic [2:0] lvl;
  logic       spurious;
  logic [2:0] lowest;

  logic [2:0] req_lvl;
  logic       req_none;
  logic [7:0] req_onehot;
  logic [2:0] hi_idx;
  logic       hi_found;
  logic [2:0] eoi_lvl_c;
  logic       eoi_hit;
  logic [7:0] eoi_clr;
  logic [7:0] aeoi_clr;
  logic [7:0] isr_set;
  logic       ack_start;
  logic       ack_end;

  assign fall = inta_d & ~inta_n;
  assign rise = ~inta_d & inta_n;

  assign ack_start = (state == IDLE) && fall;
  assign ack_end   = (state == ACK2) && rise;

  // Encode the one-hot request; no request gives the spurious level.
  always_comb begin
    req_lvl  = SPURIOUS_LEVEL;
    req_none = (interrupt == 8'd0);
    for (int i = 7; i >= 0; i--) begin
      if (interrupt[i]) req_lvl = 3'(i);
    end
    req_onehot = req_none ? 8'd0 : (8'd1 << req_lvl);
  end

  // Scan from lowest+1 upward (3-bit wrap); the first set ISR bit wins.
  always_comb begin
    hi_idx   = 3'd0;
    hi_found = 1'b0;
    highest_level_in_service = 8'd0;
    for (int k = 1; k <= 8; k++) begin
      if (!hi_found && in_service_register[lowest + 3'(k)]) begin
        hi_found = 1'b1;
        hi_idx   = lowest + 3'(k);
      end
    end
    if (hi_found) highest_level_in_service = 8'd1 << hi_idx;
  end

  // Specific EOI takes precedence over non-specific in the same cycle.
  always_comb begin
    eoi_lvl_c = hi_idx;
    eoi_hit   = 1'b0;
    eoi_clr   = 8'd0;
    if (eoi_specific) begin
      eoi_lvl_c = eoi_level;
      eoi_hit   = in_service_register[eoi_level];
    end else if (eoi_nonspecific) begin
      eoi_lvl_c = hi_idx;
      eoi_hit   = hi_found;
    end
    if (eoi_hit) eoi_clr = 8'd1 << eoi_lvl_c;
  end

  assign isr_set  = ack_start ? req_onehot : 8'd0;
  assign aeoi_clr = (ack_end && auto_eoi && !spurious) ? (8'd1 << lvl) : 8'd0;

  // ISR and rotation pointer; a set applied after clears so set wins on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_service_register <= 8'd0;
      lowest              <= 3'd7;
    end else begin
      in_service_register <= (in_service_register & ~eoi_clr & ~aeoi_clr) | isr_set;
      if (ack_end && auto_eoi && eoi_rotate) lowest <= lvl;
      else if (eoi_rotate && eoi_hit)        lowest <= eoi_lvl_c;
    end
  end

  // Acknowledge sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      inta_d      <= 1'b1;
      lvl         <= 3'd0;
      spurious    <= 1'b0;
      int_out     <= 1'b0;
      clear_irr   <= 8'd0;
      freeze      <= 1'b0;
      data_out    <= 8'd0;
      data_out_en <= 1'b0;
    end else begin
      inta_d    <= inta_n;
      clear_irr <= 8'd0;
      case (state)
        IDLE: begin
          int_out <= |interrupt;
          if (fall) begin
            lvl       <= req_lvl;
            spurious  <= req_none;
            clear_irr <= req_onehot;
            freeze    <= 1'b1;
            int_out   <= 1'b0;
            state     <= ACK1;
          end
        end
        ACK1: begin
          int_out <= 1'b0;
          if (rise) state <= WAIT2;
        end
        WAIT2: begin
          int_out <= 1'b0;
          if (fall) begin
            data_out    <= {vector_base, lvl};
            data_out_en <= 1'b1;
            state       <= ACK2;
          end
        end
        ACK2: begin
          int_out <= 1'b0;
          if (rise) begin
            data_out_en <= 1'b0;
            freeze      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
